// File: rtl/datapath_param_team1.sv
// Parametrised common-bus datapath for the basic computer.
// Register file (PC/AR/DR/AC/IR/TR/E), ALU, handshaked memory port with a
// read-data holding register (MDR), multiplexed input channels and a
// valid/ready output channel.
//
// Memory FSM
//   state      | meaning
//   ST_IDLE    | no transaction; MEM_RD/MEM_WR start one
//   ST_RD_WAIT | read request outstanding; mem_ack loads MDR
//   ST_WR_WAIT | write request outstanding; mem_ack completes it
module datapath_param_team1 #(
   parameter  int DATA_W = 16,
   parameter  int ADDR_W = 12,
   parameter  int N_IO   = 2,
   localparam int IO_W   = (N_IO > 1) ? $clog2(N_IO) : 1
) (
   input  logic                clk,
   input  logic                RST_N,
   input  logic                CLR_GLOBAL,
   input  logic [2:0]          S,
   input  logic [6:0]          LD_EN,
   input  logic [4:0]          INR_EN,
   input  logic [4:0]          CLR_EN,
   input  logic [2:0]          ALU_OP,
   input  logic                CLE,
   input  logic                CME,
   input  logic                MEM_RD,
   input  logic                MEM_WR,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                mem_ack,
   output logic                BUSY,
   input  logic [8*N_IO-1:0]   IN_DATA,
   input  logic [N_IO-1:0]     IN_VALID,
   input  logic [IO_W-1:0]     IO_SEL,
   output logic [N_IO-1:0]     IN_ACK,
   output logic [7:0]          OUT_DATA,
   output logic                OUT_VALID,
   input  logic                OUT_READY,
   output logic                FGI,
   output logic                FGO,
   output logic [ADDR_W-1:0]   out_PC,
   output logic [ADDR_W-1:0]   out_AR,
   output logic [DATA_W-1:0]   out_DR,
   output logic [DATA_W-1:0]   out_AC,
   output logic [DATA_W-1:0]   out_IR,
   output logic [DATA_W-1:0]   out_TR,
   output logic [DATA_W-1:0]   out_bus,
   output logic                out_E,
   output logic                Zero_DR
);

   // load strobe bit positions
   localparam int LD_PC   = 0;
   localparam int LD_AR   = 1;
   localparam int LD_DR   = 2;
   localparam int LD_AC   = 3;
   localparam int LD_IR   = 4;
   localparam int LD_TR   = 5;
   localparam int LD_OUTR = 6;

   // increment / clear strobe bit positions
   localparam int IX_PC = 0;
   localparam int IX_AR = 1;
   localparam int IX_DR = 2;
   localparam int IX_AC = 3;
   localparam int IX_TR = 4;

   localparam logic [2:0] OP_HOLD = 3'd0;
   localparam logic [2:0] OP_AND  = 3'd1;
   localparam logic [2:0] OP_ADD  = 3'd2;
   localparam logic [2:0] OP_LDA  = 3'd3;
   localparam logic [2:0] OP_COM  = 3'd4;
   localparam logic [2:0] OP_SHR  = 3'd5;
   localparam logic [2:0] OP_SHL  = 3'd6;
   localparam logic [2:0] OP_INP  = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_WAIT = 2'd1,
      ST_WR_WAIT = 2'd2
   } mem_state_t;

   logic [ADDR_W-1:0] pc, ar;
   logic [DATA_W-1:0] dr, ac, ir, tr, mdr;
   logic              e;
   logic [7:0]        outr;
   logic              out_valid, fgo, fgi;
   logic [DATA_W-1:0] bus;

   logic [7:0]        in_byte;
   logic              sel_valid;
   logic [N_IO-1:0]   sel_onehot;
   logic              inp_fire;

   logic [DATA_W-1:0] alu_ac;
   logic              alu_e;

   mem_state_t        state, state_nxt;
   logic              mem_start;
   logic              rd_done;

   // common bus source select; address registers are zero-extended
   always_comb begin
      bus = '0;
      case (S)
         3'd0:    bus = '0;
         3'd1:    bus = DATA_W'(ar);
         3'd2:    bus = DATA_W'(pc);
         3'd3:    bus = dr;
         3'd4:    bus = ac;
         3'd5:    bus = ir;
         3'd6:    bus = tr;
         3'd7:    bus = mdr;
         default: bus = '0;
      endcase
   end

   // input channel mux; an out-of-range IO_SEL selects nothing
   always_comb begin
      in_byte    = '0;
      sel_valid  = 1'b0;
      sel_onehot = '0;
      for (int k = 0; k < N_IO; k++) begin
         if (IO_SEL == IO_W'(k)) begin
            in_byte       = IN_DATA[8*k +: 8];
            sel_valid     = IN_VALID[k];
            sel_onehot[k] = 1'b1;
         end
      end
   end

   assign inp_fire = LD_EN[LD_AC] && (ALU_OP == OP_INP);

   // the consume pulse is raised in the same cycle the byte is taken
   always_comb begin
      IN_ACK = '0;
      if (RST_N && inp_fire) IN_ACK = sel_onehot;
   end

   // ALU result for AC and E; ops that do not touch E pass it through
   always_comb begin
      alu_ac = ac;
      alu_e  = e;
      case (ALU_OP)
         OP_HOLD: alu_ac = ac;
         OP_AND:  alu_ac = ac & dr;
         OP_ADD:  {alu_e, alu_ac} = {1'b0, ac} + {1'b0, dr};
         OP_LDA:  alu_ac = dr;
         OP_COM:  alu_ac = ~ac;
         OP_SHR:  begin
            alu_ac = {e, ac[DATA_W-1:1]};
            alu_e  = ac[0];
         end
         OP_SHL:  begin
            alu_ac = {ac[DATA_W-2:0], e};
            alu_e  = ac[DATA_W-1];
         end
         OP_INP:  alu_ac = (ac & ~DATA_W'(8'hFF)) | DATA_W'(in_byte);
         default: alu_ac = ac;
      endcase
   end

   // PC: clear > load > increment
   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N)                             pc <= '0;
      else if (CLR_GLOBAL || CLR_EN[IX_PC])   pc <= '0;
      else if (LD_EN[LD_PC])                  pc <= bus[ADDR_W-1:0];
      else if (INR_EN[IX_PC])                 pc <= pc + ADDR_W'(1);
   end

   // AR: clear > load > increment
   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N)                             ar <= '0;
      else if (CLR_GLOBAL || CLR_EN[IX_AR])   ar <= '0;
      else if (LD_EN[LD_AR])                  ar <= bus[ADDR_W-1:0];
      else if (INR_EN[IX_AR])                 ar <= ar + ADDR_W'(1);
   end

   // DR: clear > load > increment
   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N)                             dr <= '0;
      else if (CLR_GLOBAL || CLR_EN[IX_DR])   dr <= '0;
      else if (LD_EN[LD_DR])                  dr <= bus;
      else if (INR_EN[IX_DR])                 dr <= dr + DATA_W'(1);
   end

   // AC: clear > ALU write > increment
   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N)                             ac <= '0;
      else if (CLR_GLOBAL || CLR_EN[IX_AC])   ac <= '0;
      else if (LD_EN[LD_AC])                  ac <= alu_ac;
      else if (INR_EN[IX_AC])                 ac <= ac + DATA_W'(1);
   end

   // TR: clear > load > increment
   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N)                             tr <= '0;
      else if (CLR_GLOBAL || CLR_EN[IX_TR])   tr <= '0;
      else if (LD_EN[LD_TR])                  tr <= bus;
      else if (INR_EN[IX_TR])                 tr <= tr + DATA_W'(1);
   end

   // IR is load-only and survives the global clear
   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N)             ir <= '0;
      else if (LD_EN[LD_IR])  ir <= bus;
   end

   // E: explicit clear/complement override the ALU carry/shift-out
   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N)              e <= 1'b0;
      else if (CLR_GLOBAL)     e <= 1'b0;
      else if (CLE)            e <= 1'b0;
      else if (CME)            e <= ~e;
      else if (LD_EN[LD_AC])   e <= alu_e;
   end

   // input flag follows the selected channel one cycle late; INP consumes it
   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N)         fgi <= 1'b0;
      else if (inp_fire)  fgi <= 1'b0;
      else                fgi <= sel_valid;
   end

   // output channel: a new load takes precedence over a same-cycle accept
   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N) begin
         outr      <= '0;
         out_valid <= 1'b0;
         fgo       <= 1'b1;
      end else if (LD_EN[LD_OUTR]) begin
         outr      <= bus[7:0];
         out_valid <= 1'b1;
         fgo       <= 1'b0;
      end else if (out_valid && OUT_READY) begin
         out_valid <= 1'b0;
         fgo       <= 1'b1;
      end
   end

   // memory FSM state register
   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // memory FSM next state and request outputs; read wins over write
   always_comb begin
      state_nxt = state;
      mem_start = 1'b0;
      rd_done   = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (MEM_RD) begin
               state_nxt = ST_RD_WAIT;
               mem_start = 1'b1;
            end else if (MEM_WR) begin
               state_nxt = ST_WR_WAIT;
               mem_start = 1'b1;
            end
         end
         ST_RD_WAIT: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               state_nxt = ST_IDLE;
               rd_done   = 1'b1;
            end
         end
         ST_WR_WAIT: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            if (mem_ack) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign BUSY = mem_req;

   // address/data are captured at request start and held until completion
   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N) begin
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else if (mem_start) begin
         mem_addr  <= ar;
         mem_wdata <= bus;
      end
   end

   // MDR: a completing read is never lost to a coincident global clear
   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N)          mdr <= '0;
      else if (rd_done)    mdr <= mem_rdata;
      else if (CLR_GLOBAL) mdr <= '0;
   end

   assign OUT_DATA  = outr;
   assign OUT_VALID = out_valid;
   assign FGI       = fgi;
   assign FGO       = fgo;
   assign out_PC    = pc;
   assign out_AR    = ar;
   assign out_DR    = dr;
   assign out_AC    = ac;
   assign out_IR    = ir;
   assign out_TR    = tr;
   assign out_bus   = bus;
   assign out_E     = e;
   assign Zero_DR   = (dr == '0);

endmodule

// File: tb/tb_datapath_param_team1.sv
// Directed bench for datapath_param_team1 with default parameters.
module tb_datapath_param_team1;

   logic        clk = 1'b0;
   logic        RST_N;
   logic        CLR_GLOBAL;
   logic [2:0]  S;
   logic [6:0]  LD_EN;
   logic [4:0]  INR_EN, CLR_EN;
   logic [2:0]  ALU_OP;
   logic        CLE, CME, MEM_RD, MEM_WR;
   logic        mem_req, mem_we;
   logic [11:0] mem_addr;
   logic [15:0] mem_wdata, mem_rdata;
   logic        mem_ack, BUSY;
   logic [15:0] IN_DATA;
   logic [1:0]  IN_VALID;
   logic [0:0]  IO_SEL;
   logic [1:0]  IN_ACK;
   logic [7:0]  OUT_DATA;
   logic        OUT_VALID, OUT_READY, FGI, FGO;
   logic [11:0] out_PC, out_AR;
   logic [15:0] out_DR, out_AC, out_IR, out_TR, out_bus;
   logic        out_E, Zero_DR;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   datapath_param_team1 dut (
      .clk(clk), .RST_N(RST_N), .CLR_GLOBAL(CLR_GLOBAL), .S(S), .LD_EN(LD_EN),
      .INR_EN(INR_EN), .CLR_EN(CLR_EN), .ALU_OP(ALU_OP), .CLE(CLE), .CME(CME),
      .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ack(mem_ack), .BUSY(BUSY), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID),
      .IO_SEL(IO_SEL), .IN_ACK(IN_ACK), .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID),
      .OUT_READY(OUT_READY), .FGI(FGI), .FGO(FGO), .out_PC(out_PC), .out_AR(out_AR),
      .out_DR(out_DR), .out_AC(out_AC), .out_IR(out_IR), .out_TR(out_TR),
      .out_bus(out_bus), .out_E(out_E), .Zero_DR(Zero_DR)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      CLR_GLOBAL = 0; S = 0; LD_EN = 0; INR_EN = 0; CLR_EN = 0; ALU_OP = 0;
      CLE = 0; CME = 0; MEM_RD = 0; MEM_WR = 0; mem_ack = 0;
   endtask

   // single read with minimum latency, leaves value in MDR
   task automatic mem_read(input logic [15:0] data);
      MEM_RD = 1; tick(); MEM_RD = 0;
      mem_rdata = data; mem_ack = 1; tick(); mem_ack = 0;
   endtask

   initial begin
      idle_inputs();
      RST_N = 0; mem_rdata = 0; IN_DATA = 0; IN_VALID = 0; IO_SEL = 0; OUT_READY = 0;
      #23;
      check_val("rst_pc", out_PC, 0);
      check_val("rst_ac", out_AC, 0);
      check_val("rst_e", out_E, 0);
      check_val("rst_req", mem_req, 0);
      check_val("rst_busy", BUSY, 0);
      check_val("rst_ovalid", OUT_VALID, 0);
      check_val("rst_fgo", FGO, 1);
      check_val("rst_inack", IN_ACK, 0);
      @(negedge clk); RST_N = 1;
      tick();

      // AR = 0x005 through MDR
      MEM_RD = 1; tick(); MEM_RD = 0;
      check_val("rd0_req", mem_req, 1);
      check_val("rd0_addr", mem_addr, 12'h000);
      mem_rdata = 16'h0005; mem_ack = 1; tick(); mem_ack = 0;
      check_val("rd0_busy_low", BUSY, 0);
      S = 7; LD_EN = 7'b0000010; tick(); LD_EN = 0;
      check_val("ar_load", out_AR, 12'h005);

      // PC = 0xFFF via AC = ~0, then wrap
      ALU_OP = 4; LD_EN = 7'b0001000; tick(); LD_EN = 0; ALU_OP = 0;
      check_val("ac_com", out_AC, 16'hFFFF);
      S = 4; LD_EN = 7'b0000001; tick(); LD_EN = 0;
      check_val("pc_load", out_PC, 12'hFFF);
      INR_EN = 5'b00001; tick(); INR_EN = 0;
      check_val("pc_wrap", out_PC, 12'h000);
      check_val("ar_hold", out_AR, 12'h005);
      INR_EN = 5'b00001; tick();
      check_val("pc_inr", out_PC, 12'h001);
      CLR_EN = 5'b00001; tick(); CLR_EN = 0;
      check_val("pc_clr_over_inr", out_PC, 12'h000);
      S = 1; LD_EN = 7'b0000001; tick(); LD_EN = 0; INR_EN = 0;
      check_val("pc_ld_over_inr", out_PC, 12'h005);

      // DR = 1, ADD / SHR / SHL, E control
      CLR_EN = 5'b00100; tick(); CLR_EN = 0;
      check_val("zero_dr_set", Zero_DR, 1);
      INR_EN = 5'b00100; tick(); INR_EN = 0;
      check_val("dr_inr", out_DR, 16'h0001);
      check_val("zero_dr_clr", Zero_DR, 0);
      ALU_OP = 2; LD_EN = 7'b0001000; tick();
      check_val("add_ac", out_AC, 16'h0000);
      check_val("add_e", out_E, 1);
      ALU_OP = 5; tick();
      check_val("shr_ac", out_AC, 16'h8000);
      check_val("shr_e", out_E, 0);
      ALU_OP = 6; tick(); LD_EN = 0; ALU_OP = 0;
      check_val("shl_ac", out_AC, 16'h0000);
      check_val("shl_e", out_E, 1);
      CME = 1; tick();
      check_val("cme", out_E, 0);
      CLE = 1; tick(); CLE = 0; CME = 0;
      check_val("cle_over_cme", out_E, 0);

      // read AR = 0x123 with 3-cycle request, WR during BUSY ignored
      mem_read(16'h0123);
      S = 7; LD_EN = 7'b0000010; tick(); LD_EN = 0;
      MEM_RD = 1; tick(); MEM_RD = 0;
      check_val("rd_req_c1", mem_req, 1);
      check_val("rd_addr", mem_addr, 12'h123);
      check_val("rd_we", mem_we, 0);
      MEM_WR = 1; tick(); MEM_WR = 0;
      check_val("rd_req_c2", mem_req, 1);
      tick();
      check_val("rd_req_c3", BUSY, 1);
      mem_rdata = 16'hBEEF; mem_ack = 1; tick(); mem_ack = 0;
      check_val("rd_busy_after_ack", BUSY, 0);
      S = 7; #1;
      check_val("mdr_bus", out_bus, 16'hBEEF);
      tick();
      check_val("no_second_req", mem_req, 0);
      mem_rdata = 16'h1234; mem_ack = 1; tick(); mem_ack = 0;
      check_val("idle_ack_ignored", out_bus, 16'hBEEF);

      // write with bus = MDR, then RD+WR together
      MEM_WR = 1; tick(); MEM_WR = 0;
      check_val("wr_we", mem_we, 1);
      check_val("wr_data", mem_wdata, 16'hBEEF);
      check_val("wr_addr", mem_addr, 12'h123);
      mem_ack = 1; tick(); mem_ack = 0;
      check_val("wr_done", BUSY, 0);
      MEM_RD = 1; MEM_WR = 1; tick(); MEM_RD = 0; MEM_WR = 0;
      check_val("rd_wins_we", mem_we, 0);
      check_val("rd_wins_req", mem_req, 1);
      mem_rdata = 16'h0041; mem_ack = 1; tick(); mem_ack = 0;

      // output channel
      S = 7; LD_EN = 7'b1000000; tick(); LD_EN = 0;
      check_val("outr_data", OUT_DATA, 8'h41);
      check_val("outr_valid", OUT_VALID, 1);
      check_val("outr_fgo", FGO, 0);
      tick();
      check_val("outr_hold", OUT_VALID, 1);
      OUT_READY = 1; tick(); OUT_READY = 0;
      check_val("outr_accept", OUT_VALID, 0);
      check_val("outr_fgo_set", FGO, 1);
      LD_EN = 7'b1000000; tick();
      S = 3; OUT_READY = 1; tick(); LD_EN = 0;
      check_val("ld_wins_valid", OUT_VALID, 1);
      check_val("ld_wins_fgo", FGO, 0);
      check_val("ld_wins_data", OUT_DATA, 8'h01);
      tick(); OUT_READY = 0;
      check_val("outr_drain", OUT_VALID, 0);

      // input channels
      ALU_OP = 4; LD_EN = 7'b0001000; tick(); LD_EN = 0; ALU_OP = 0;
      IN_VALID = 2'b10; IN_DATA = 16'h5A11; IO_SEL = 1; tick();
      check_val("fgi_set", FGI, 1);
      ALU_OP = 7; LD_EN = 7'b0001000; #1;
      check_val("inack_ch1", IN_ACK, 2'b10);
      tick(); LD_EN = 0; ALU_OP = 0; #1;
      check_val("inp_ac", out_AC, 16'hFF5A);
      check_val("inack_drop", IN_ACK, 2'b00);
      check_val("fgi_cleared", FGI, 0);
      tick();
      check_val("fgi_reset_by_valid", FGI, 1);
      IO_SEL = 0; tick();
      check_val("fgi_ch0", FGI, 0);
      ALU_OP = 7; LD_EN = 7'b0001000; #1;
      check_val("inack_ch0", IN_ACK, 2'b01);
      tick(); LD_EN = 0; ALU_OP = 0;
      check_val("inp_ac_ch0", out_AC, 16'hFF11);

      // IR survives global clear, MDR does not
      S = 7; LD_EN = 7'b0010000; tick(); LD_EN = 0;
      check_val("ir_load", out_IR, 16'h0041);
      CLR_GLOBAL = 1; tick(); CLR_GLOBAL = 0;
      check_val("gclr_ac", out_AC, 16'h0000);
      check_val("gclr_ir", out_IR, 16'h0041);
      check_val("gclr_mdr", out_bus, 16'h0000);

      // reset while a read is outstanding
      MEM_RD = 1; tick(); MEM_RD = 0;
      check_val("rd_busy_pre_rst", BUSY, 1);
      RST_N = 0; #1;
      check_val("rst_mid_req", mem_req, 0);
      check_val("rst_mid_busy", BUSY, 0);
      check_val("rst_mid_ir", out_IR, 16'h0000);
      check_val("rst_mid_fgo", FGO, 1);
      check_val("rst_mid_pc", out_PC, 12'h000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/datapath_param_team1.md
Name: datapath_param_team1

Overview:
- Parametrised next-generation common-bus datapath for the basic-computer processor. Adds configurable data/address width and a handshaked variable-latency memory port with a read-data holding register (MDR).
- Adds N_IO multiplexed 8-bit input channels with FGI, and a valid/ready output channel with FGO.
- Sits between the control unit (which drives select/load/op strobes) and external memory/IO.

Parameters:
- DATA_W, 16, width of DR/AC/IR/TR/MDR and the bus
- ADDR_W, 12, width of PC/AR and the memory address; must be ≤ DATA_W
- N_IO, 2, number of 8-bit input channels; must be ≥ 1

Ports:
- clk  in  1  rising-edge clock
- RST_N  in  1  asynchronous active-low reset
- CLR_GLOBAL  in  1  synchronous clear of PC/AR/DR/AC/TR/E/MDR
- S  in  3  bus select: 0 zero, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 MDR
- LD_EN  in  7  load strobes, bit order {OUTR,TR,IR,AC,DR,AR,PC}
- INR_EN  in  5  increment strobes, bit order {TR,AC,DR,AR,PC}
- CLR_EN  in  5  clear strobes, same bit order as INR_EN
- ALU_OP  in  3  0 hold, 1 AND, 2 ADD, 3 LDA, 4 COM, 5 SHR, 6 SHL, 7 INP
- CLE, CME  in  1  clear / complement E
- MEM_RD, MEM_WR  in  1  start a memory transaction (single-cycle pulse)
- mem_req  out  1  memory request
- mem_we  out  1  1 = write request
- mem_addr  out  ADDR_W  address of the request
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, valid while mem_ack is high
- mem_ack  in  1  memory completion
- BUSY  out  1  a memory transaction is in flight
- IN_DATA  in  8*N_IO  input channels, channel k at bits [8k+7:8k]
- IN_VALID  in  N_IO  per-channel data-valid
- IO_SEL  in  clog2(N_IO) (min 1)  selected input channel
- IN_ACK  out  N_IO  one-cycle consume pulse to the selected channel
- OUT_DATA  out  8  OUTR contents
- OUT_VALID  out  1  OUTR holds unconsumed data
- OUT_READY  in  1  consumer accepts
- FGI, FGO  out  1  input flag / output-ready flag
- out_PC, out_AR  out  ADDR_W  register taps
- out_DR, out_AC, out_IR, out_TR, out_bus  out  DATA_W  register and bus taps
- out_E  out  1  E flag
- Zero_DR  out  1  DR == 0

Behaviour:
- Reset (RST_N low, asynchronous): all registers, E and MDR = 0; FSM = IDLE; mem_req = 0; BUSY = 0; OUT_VALID = 0; FGO = 1; IN_ACK = 0.
- Bus is combinational from S. AR/PC are zero-extended to DATA_W. Registers load bus bits [width-1:0].
- Per-register priority: CLR_GLOBAL > CLR_EN > LD_EN > INR_EN. INR wraps modulo 2^width (all-ones -> 0). IR has load only.
- AC is written on LD_EN[AC] with the ALU result. ALU_OP 0 leaves AC unchanged.
  - AND: AC & DR.
  - ADD: {E, AC} = AC + DR.
  - LDA: DR.
  - COM: ~AC.
  - SHR: {AC, E} <= {E, AC} rotated right (E -> MSB, AC[0] -> E).
  - SHL: MSB -> E, E -> AC[0].
  - INP: AC[7:0] = IN_DATA of channel IO_SEL, upper bits kept. Same cycle: IN_ACK[IO_SEL] pulses and FGI clears.
- E is updated only on ADD/SHR/SHL with LD_EN[AC]. CLE/CME override in the same cycle, CLE > CME.
- FGI = IN_VALID[IO_SEL], registered (one-cycle lag). INP with FGI = 0 still loads and still pulses IN_ACK.
- LD_EN[OUTR]: OUTR = bus[7:0], OUT_VALID = 1, FGO = 0.
  - When OUT_VALID && OUT_READY: OUT_VALID = 0, FGO = 1 on the next edge.
  - If a load and an accept occur in the same cycle, the load wins: the new data stays valid and FGO = 0.
- Memory FSM states: IDLE, RD_WAIT, WR_WAIT.
  - IDLE + MEM_RD: capture AR -> mem_addr, go to RD_WAIT; mem_req = 1, mem_we = 0.
  - IDLE + MEM_WR: capture AR and the bus -> mem_wdata, go to WR_WAIT; mem_we = 1.
  - MEM_RD and MEM_WR together: read wins.
  - MEM_RD/MEM_WR while BUSY: ignored.
  - mem_ack in RD_WAIT: MDR = mem_rdata, back to IDLE. mem_ack in WR_WAIT: back to IDLE.
  - mem_ack in IDLE: ignored.
  - Address and data stay stable while mem_req is high. Minimum latency: request on edge n, ack sampled at n+1, BUSY low at n+2.
  - BUSY = (state != IDLE).
- CLR_GLOBAL mid-transaction: FSM unaffected; MDR is cleared, then overwritten by the pending ack. RST_N aborts the transaction to IDLE.

Test Plan:
- Reset, then load AR = 0x005 via S=7/MDR path, and PC = 0xFFF; INR PC -> out_PC = 0x000, out_AR = 0x005.
- AC = 0xFFFF, DR = 0x0001, ALU_OP = ADD, LD AC -> out_AC = 0x0000, out_E = 1. Then SHR -> AC = 0x8000, E = 0.
- MEM_RD with AR = 0x123, memory acks 3 cycles later with 0xBEEF:
  - mem_req high for 3 cycles, mem_addr = 0x123, BUSY low 1 cycle after the ack.
  - S = 7 shows 0xBEEF.
  - A MEM_WR pulsed during BUSY produces no second request.
- N_IO = 2, IN_VALID = 2'b10, IN_DATA = {0x5A, 0x11}, IO_SEL = 1: FGI = 1; INP -> AC[7:0] = 0x5A, IN_ACK = 2'b10 for one cycle.
- LD OUTR with bus = 0x0041, OUT_READY held low -> OUT_DATA = 0x41, OUT_VALID = 1, FGO = 0. Raise OUT_READY -> next cycle OUT_VALID = 0, FGO = 1.
- Assert RST_N low while in RD_WAIT -> mem_req = 0, BUSY = 0 immediately; all taps = 0, FGO = 1.
